// File: rtl/dmem_resp_pkg.sv
// Shared types and helpers for the data-memory responder.
// Holds the FSM state enum, word size and the address check.
package dmem_resp_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_t;

  localparam int WORD_BYTES = 4;

  // Good means word aligned and inside the 2^(aw+2)-byte window.
  function automatic logic addr_ok(
    input logic [31:0] addr,
    input int          aw
  );
    logic aligned;
    logic in_range;
    aligned  = (addr & 32'(WORD_BYTES - 1)) == 32'd0;
    in_range = (addr >> (aw + 2)) == 32'd0;
    return aligned && in_range;
  endfunction

endpackage

// File: rtl/dmem_array.sv
// DEPTH x 32 RAM: synchronous write, combinational read.
// Ports: clk, we/wa/wd write port, ra/rd read port.
module dmem_array #(
  parameter int DEPTH = 64,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] wa,
  input  logic [31:0]   wd,
  input  logic [AW-1:0] ra,
  output logic [31:0]   rd
);

  logic [31:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[wa] <= wd;
  end

  assign rd = mem[ra];

endmodule

// File: rtl/dmem_resp.sv
// Multi-cycle data-memory responder with req/ready handshake.
// Ports: clk, reset (async, active-low), req/we/addr/wdata in;
//        ready/rdata/err registered out, busy decoded from state.
module dmem_resp
  import dmem_resp_pkg::*;
#(
  parameter int DEPTH   = 64,
  parameter int LATENCY = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        we,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        ready,
  output logic [31:0] rdata,
  output logic        err,
  output logic        busy
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(LATENCY + 1);

  state_t        state, state_nx;
  logic [CW-1:0] cnt, cnt_nx;
  logic          lat_we, lat_we_nx;
  logic [31:0]   lat_addr, lat_addr_nx;
  logic [31:0]   lat_wdata, lat_wdata_nx;
  logic          ready_nx, err_nx;
  logic [31:0]   rdata_nx;
  logic          mem_we;
  logic [31:0]   mem_rd;
  logic          good;

  // Only the latched address is ever checked or used.
  assign good = addr_ok(lat_addr, AW);
  assign busy = (state != IDLE);

  dmem_array #(
    .DEPTH(DEPTH)
  ) u_array (
    .clk(clk),
    .we (mem_we),
    .wa (lat_addr[AW+1:2]),
    .wd (lat_wdata),
    .ra (lat_addr[AW+1:2]),
    .rd (mem_rd)
  );

  always_comb begin
    state_nx     = state;
    cnt_nx       = cnt;
    lat_we_nx    = lat_we;
    lat_addr_nx  = lat_addr;
    lat_wdata_nx = lat_wdata;
    ready_nx     = ready;
    err_nx       = err;
    rdata_nx     = rdata;
    mem_we       = 1'b0;
    unique case (state)
      IDLE: begin
        if (req) begin
          lat_we_nx    = we;
          lat_addr_nx  = addr;
          lat_wdata_nx = wdata;
          cnt_nx       = CW'(LATENCY - 1);
          state_nx     = WAIT;
        end
      end
      WAIT: begin
        if (cnt != '0) begin
          cnt_nx = cnt - CW'(1);
        end else begin
          // Commit edge: access and response launch together.
          state_nx = RESP;
          ready_nx = 1'b1;
          if (!good) begin
            rdata_nx = '0;
            err_nx   = 1'b1;
          end else if (lat_we) begin
            mem_we = 1'b1;
          end else begin
            rdata_nx = mem_rd;
          end
        end
      end
      RESP: begin
        ready_nx = 1'b0;
        err_nx   = 1'b0;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      cnt       <= '0;
      lat_we    <= 1'b0;
      lat_addr  <= '0;
      lat_wdata <= '0;
      ready     <= 1'b0;
      err       <= 1'b0;
      rdata     <= '0;
    end else begin
      state     <= state_nx;
      cnt       <= cnt_nx;
      lat_we    <= lat_we_nx;
      lat_addr  <= lat_addr_nx;
      lat_wdata <= lat_wdata_nx;
      ready     <= ready_nx;
      err       <= err_nx;
      rdata     <= rdata_nx;
    end
  end

endmodule

// File: tb/tb_dmem_resp.sv
// Self-checking bench for dmem_resp at LATENCY 2, 1 and 5.
// Random and directed accesses are checked against a word-array model.
module tb_dmem_resp;

  logic        clk = 1'b0;
  logic        reset;
  logic        req   [3];
  logic        we    [3];
  logic [31:0] addr  [3];
  logic [31:0] wdata [3];
  logic        ready [3];
  logic [31:0] rdata [3];
  logic        err   [3];
  logic        busy  [3];

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] mem_m   [3][64];
  logic [31:0] last_rd [3];

  always #5 clk = ~clk;

  dmem_resp #(.DEPTH(64), .LATENCY(2)) u0 (
    .clk(clk), .reset(reset), .req(req[0]), .we(we[0]),
    .addr(addr[0]), .wdata(wdata[0]), .ready(ready[0]),
    .rdata(rdata[0]), .err(err[0]), .busy(busy[0])
  );
  dmem_resp #(.DEPTH(64), .LATENCY(1)) u1 (
    .clk(clk), .reset(reset), .req(req[1]), .we(we[1]),
    .addr(addr[1]), .wdata(wdata[1]), .ready(ready[1]),
    .rdata(rdata[1]), .err(err[1]), .busy(busy[1])
  );
  dmem_resp #(.DEPTH(64), .LATENCY(5)) u2 (
    .clk(clk), .reset(reset), .req(req[2]), .we(we[2]),
    .addr(addr[2]), .wdata(wdata[2]), .ready(ready[2]),
    .rdata(rdata[2]), .err(err[2]), .busy(busy[2])
  );

  function automatic int lat_of(input int k);
    if (k == 1) return 1;
    if (k == 2) return 5;
    return 2;
  endfunction

  // Reference: 256-byte word RAM; misaligned or >= 256 is an error.
  task automatic model(input int k, input logic w,
                       input logic [31:0] a, input logic [31:0] d,
                       output logic [31:0] er, output logic ee);
    if ((a % 4) != 0 || a >= 256) begin
      last_rd[k] = 32'd0;
      ee = 1'b1;
    end else if (w) begin
      mem_m[k][a / 4] = d;
      ee = 1'b0;
    end else begin
      last_rd[k] = mem_m[k][a / 4];
      ee = 1'b0;
    end
    er = last_rd[k];
  endtask

  // Drives one access; returns edges from acceptance to ready.
  task automatic access(input int k, input logic w,
                        input logic [31:0] a, input logic [31:0] d,
                        output int cyc, output logic [31:0] rd,
                        output logic e, output logic b1,
                        output logic rd_after);
    @(negedge clk);
    req[k] = 1'b1; we[k] = w; addr[k] = a; wdata[k] = d;
    cyc = -1; rd = 'x; e = 'x; b1 = 1'b0;
    for (int n = 1; n <= 20; n++) begin
      @(posedge clk); #1;
      if (n == 1) b1 = busy[k];
      if (ready[k]) begin
        cyc = n; rd = rdata[k]; e = err[k];
        break;
      end
    end
    req[k] = 1'b0;
    @(posedge clk); #1;
    rd_after = ready[k];
  endtask

  task automatic test_reset();
    reset = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      for (int k = 0; k < 3; k++) begin
        n_tests++;
        if (ready[k] !== 1'b0 || err[k] !== 1'b0 ||
            busy[k] !== 1'b0 || rdata[k] !== 32'd0) begin
          n_fail++;
          $display("FAIL reset dut%0d rdy=%b err=%b busy=%b rd=%h want 0",
                   k, ready[k], err[k], busy[k], rdata[k]);
        end
      end
    end
    reset = 1'b1;
    for (int k = 0; k < 3; k++) last_rd[k] = 32'd0;
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      n_tests++;
      if (ready[k] !== 1'b0 || busy[k] !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_idle dut%0d rdy=%b busy=%b want 0 0",
                 k, ready[k], busy[k]);
      end
    end
  endtask

  task automatic test_fill();
    int cyc; logic [31:0] rd, er; logic e, ee, b1, ra;
    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < 64; i++) begin
        logic [31:0] a, d;
        a = 32'(i * 4); d = $urandom;
        access(k, 1'b1, a, d, cyc, rd, e, b1, ra);
        model(k, 1'b1, a, d, er, ee);
        n_tests++;
        if (cyc !== lat_of(k) + 1 || e !== ee) begin
          n_fail++;
          $display("FAIL fill dut%0d a=%h cyc=%0d err=%b want %0d %b",
                   k, a, cyc, e, lat_of(k) + 1, ee);
        end
      end
    end
  endtask

  task automatic test_store_load();
    int cyc; logic [31:0] rd, er; logic e, ee, b1, ra;
    access(0, 1'b1, 32'h64, 32'd7, cyc, rd, e, b1, ra);
    model(0, 1'b1, 32'h64, 32'd7, er, ee);
    n_tests++;
    if (cyc !== 3 || e !== 1'b0 || b1 !== 1'b1 || ra !== 1'b0) begin
      n_fail++;
      $display("FAIL st_store cyc=%0d err=%b busy=%b after=%b want 3 0 1 0",
               cyc, e, b1, ra);
    end
    access(0, 1'b0, 32'h64, 32'd0, cyc, rd, e, b1, ra);
    model(0, 1'b0, 32'h64, 32'd0, er, ee);
    n_tests++;
    if (cyc !== 3 || e !== 1'b0 || rd !== 32'd7 || rd !== er) begin
      n_fail++;
      $display("FAIL st_load cyc=%0d err=%b rd=%h want 3 0 00000007",
               cyc, e, rd);
    end
  endtask

  task automatic test_latency();
    int cyc; logic [31:0] rd, er; logic e, ee, b1, ra;
    for (int k = 1; k < 3; k++) begin
      access(k, 1'b0, 32'h60, 32'd0, cyc, rd, e, b1, ra);
      model(k, 1'b0, 32'h60, 32'd0, er, ee);
      n_tests++;
      if (cyc !== lat_of(k) + 1 || ra !== 1'b0 ||
          rd !== er || e !== 1'b0) begin
        n_fail++;
        $display("FAIL latency dut%0d cyc=%0d after=%b rd=%h want %0d 0 %h",
                 k, cyc, ra, rd, lat_of(k) + 1, er);
      end
    end
  endtask

  task automatic test_bad_addr();
    int cyc; logic [31:0] rd, er; logic e, ee, b1, ra;
    access(0, 1'b1, 32'h62, 32'h1234, cyc, rd, e, b1, ra);
    model(0, 1'b1, 32'h62, 32'h1234, er, ee);
    n_tests++;
    if (cyc !== 3 || e !== 1'b1 || rd !== 32'd0) begin
      n_fail++;
      $display("FAIL bad_mis cyc=%0d err=%b rd=%h want 3 1 0", cyc, e, rd);
    end
    access(0, 1'b0, 32'h60, 32'd0, cyc, rd, e, b1, ra);
    model(0, 1'b0, 32'h60, 32'd0, er, ee);
    n_tests++;
    if (e !== 1'b0 || rd !== er) begin
      n_fail++;
      $display("FAIL bad_keep err=%b rd=%h want 0 %h", e, rd, er);
    end
    access(0, 1'b0, 32'h100, 32'd0, cyc, rd, e, b1, ra);
    model(0, 1'b0, 32'h100, 32'd0, er, ee);
    n_tests++;
    if (cyc !== 3 || e !== 1'b1 || rd !== 32'd0) begin
      n_fail++;
      $display("FAIL bad_range cyc=%0d err=%b rd=%h want 3 1 0", cyc, e, rd);
    end
  endtask

  task automatic test_reset_wait();
    int cyc; logic [31:0] rd, er; logic e, ee, b1, ra;
    @(negedge clk);
    req[0] = 1'b1; we[0] = 1'b1;
    addr[0] = 32'h10; wdata[0] = 32'hDEADBEEF;
    @(posedge clk); #1;
    reset = 1'b0;
    #1;
    n_tests++;
    if (busy[0] !== 1'b0 || ready[0] !== 1'b0 || rdata[0] !== 32'd0) begin
      n_fail++;
      $display("FAIL rst_wait busy=%b rdy=%b rd=%h want 0 0 0",
               busy[0], ready[0], rdata[0]);
    end
    req[0] = 1'b0;
    for (int k = 0; k < 3; k++) last_rd[k] = 32'd0;
    @(negedge clk);
    reset = 1'b1;
    access(0, 1'b0, 32'h10, 32'd0, cyc, rd, e, b1, ra);
    model(0, 1'b0, 32'h10, 32'd0, er, ee);
    n_tests++;
    if (cyc !== 3 || e !== 1'b0 || rd !== er) begin
      n_fail++;
      $display("FAIL rst_nowrite cyc=%0d err=%b rd=%h want 3 0 %h",
               cyc, e, rd, er);
    end
  endtask

  task automatic test_ignored();
    int cyc; logic [31:0] rd, er; logic e, ee, b1, ra;
    cyc = -1;
    @(negedge clk);
    req[0] = 1'b1; we[0] = 1'b1;
    addr[0] = 32'h08; wdata[0] = 32'hA5;
    @(posedge clk); #1;
    addr[0] = 32'h20; wdata[0] = 32'h55;
    for (int n = 2; n <= 20; n++) begin
      @(posedge clk); #1;
      if (ready[0]) begin cyc = n; break; end
    end
    req[0] = 1'b0;
    @(posedge clk); #1;
    model(0, 1'b1, 32'h08, 32'hA5, er, ee);
    n_tests++;
    if (cyc !== 3) begin
      n_fail++;
      $display("FAIL ign_store cyc=%0d want 3", cyc);
    end
    access(0, 1'b0, 32'h08, 32'd0, cyc, rd, e, b1, ra);
    model(0, 1'b0, 32'h08, 32'd0, er, ee);
    n_tests++;
    if (rd !== er || rd !== 32'hA5) begin
      n_fail++;
      $display("FAIL ign_a08 rd=%h want %h", rd, er);
    end
    access(0, 1'b0, 32'h20, 32'd0, cyc, rd, e, b1, ra);
    model(0, 1'b0, 32'h20, 32'd0, er, ee);
    n_tests++;
    if (rd !== er) begin
      n_fail++;
      $display("FAIL ign_a20 rd=%h want %h", rd, er);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] er; logic ee;
    for (int k = 0; k < 3; k++) begin
      int n1, n2;
      logic [31:0] r1, r2;
      n1 = -1; n2 = -1; r1 = 'x; r2 = 'x;
      @(negedge clk);
      req[k] = 1'b1; we[k] = 1'b0; addr[k] = 32'h64;
      for (int n = 1; n <= 20; n++) begin
        @(posedge clk); #1;
        if (ready[k]) begin n1 = n; r1 = rdata[k]; break; end
      end
      model(k, 1'b0, 32'h64, 32'd0, er, ee);
      n_tests++;
      if (n1 !== lat_of(k) + 1 || r1 !== er) begin
        n_fail++;
        $display("FAIL b2b_first dut%0d cyc=%0d rd=%h want %0d %h",
                 k, n1, r1, lat_of(k) + 1, er);
      end
      addr[k] = 32'h60;
      for (int n = 1; n <= 20; n++) begin
        @(posedge clk); #1;
        if (ready[k]) begin n2 = n; r2 = rdata[k]; break; end
      end
      req[k] = 1'b0;
      model(k, 1'b0, 32'h60, 32'd0, er, ee);
      n_tests++;
      if (n2 !== lat_of(k) + 2 || r2 !== er) begin
        n_fail++;
        $display("FAIL b2b_second dut%0d gap=%0d rd=%h want %0d %h",
                 k, n2, r2, lat_of(k) + 2, er);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_random();
    int cyc; logic [31:0] rd, er; logic e, ee, b1, ra;
    for (int i = 0; i < 60; i++) begin
      int k, sel;
      logic w;
      logic [31:0] a, d;
      k = $urandom_range(0, 2);
      w = 1'($urandom_range(0, 1));
      sel = $urandom_range(0, 5);
      if (sel == 0)
        a = 32'($urandom_range(0, 63) * 4 + $urandom_range(1, 3));
      else if (sel == 1)
        a = $urandom | 32'h100;
      else
        a = 32'($urandom_range(0, 63) * 4);
      d = $urandom;
      access(k, w, a, d, cyc, rd, e, b1, ra);
      model(k, w, a, d, er, ee);
      n_tests++;
      if (cyc !== lat_of(k) + 1 || e !== ee || rd !== er ||
          b1 !== 1'b1 || ra !== 1'b0) begin
        n_fail++;
        $display("FAIL rand%0d dut%0d a=%h we=%b cyc=%0d err=%b rd=%h want %0d %b %h",
                 i, k, a, w, cyc, e, rd, lat_of(k) + 1, ee, er);
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int k = 0; k < 3; k++) begin
      req[k] = 1'b0; we[k] = 1'b0;
      addr[k] = 32'd0; wdata[k] = 32'd0;
      last_rd[k] = 32'd0;
    end
    test_reset();
    test_fill();
    test_store_load();
    test_latency();
    test_bad_addr();
    test_reset_wait();
    test_ignored();
    test_back_to_back();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
